// File: rtl/ahb_dmem_slave_bridge.sv
// AHB-Lite slave bridge to the word-wide data memory, with wait states and subword RMW.
// Optional DMEM_ERROR_RESP_EN adds ERROR responses for misaligned, oversize and out-of-range accesses.
module ahb_dmem_slave_bridge #(
  parameter int MEM_BYTES   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_sel,
  output logic [31:0] address_ram,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    RMW_WR,
    ERR1,
    ERR2
  } state_t;

  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);
  localparam logic [2:0]  WS        = 3'(WAIT_STATES);

  state_t      state;
  logic [31:0] addr_q;
  logic        write_q;
  logic [2:0]  size_q;
  logic [2:0]  cnt;
  logic [31:0] merge;
  logic [31:0] merged;
  logic [31:0] word_addr;
  logic [3:0]  lanes;
  logic        accept;
  logic        sub;
  logic        done;
  logic        access_err;

  assign accept    = HSEL & HREADY & HTRANS[1];
  assign sub       = (size_q == 3'b000) | (size_q == 3'b001);
  assign word_addr = {addr_q[31:2], 2'b00} & ADDR_MASK;

`ifdef DMEM_ERROR_RESP_EN
  assign access_err = (HSIZE > 3'b010)
                    | ((HSIZE == 3'b001) & HADDR[0])
                    | ((HSIZE == 3'b010) & (HADDR[1:0] != 2'b00))
                    | (HADDR >= 32'(MEM_BYTES));
`else
  assign access_err = 1'b0;
`endif

  always_comb begin
    lanes = 4'b0000;
    unique case (1'b1)
      size_q == 3'b000: lanes = 4'b0001 << addr_q[1:0];
      size_q == 3'b001: lanes = addr_q[1] ? 4'b1100 : 4'b0011;
      default:          lanes = 4'b0000;
    endcase
  end

  always_comb begin
    merged = read_data;
    for (int i = 0; i < 4; i++)
      if (lanes[i]) merged[8*i +: 8] = HWDATA[8*i +: 8];
  end

  // Cycles in which our data phase completes and a new address may land
  always_comb begin
    done = 1'b0;
    unique case (state)
      IDLE, ERR2, RMW_WR: done = 1'b1;
      DATA:    done = (cnt == 3'd0) & ~(write_q & sub);
      default: done = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      merge   <= 32'd0;
      addr_q  <= 32'd0;
      write_q <= 1'b0;
      size_q  <= 3'b000;
    end else if (done) begin
      if (accept) begin
        addr_q  <= HADDR;
        write_q <= HWRITE;
        size_q  <= HSIZE;
        cnt     <= access_err ? 3'd0 : WS;
        state   <= access_err ? ERR1 : DATA;
      end else begin
        state <= IDLE;
      end
    end else begin
      unique case (state)
        DATA: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            merge <= merged;
            state <= RMW_WR;
          end
        end
        ERR1:    state <= ERR2;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    HREADYOUT   = 1'b1;
    HRESP       = 1'b0;
    HRDATA      = 32'd0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    address_ram = 32'd0;
    write_data  = 32'd0;
    unique case (state)
      DATA: begin
        address_ram = word_addr;
        if (cnt != 3'd0) begin
          HREADYOUT = 1'b0;
        end else if (!write_q) begin
          mem_read = 1'b1;
          HRDATA   = read_data;
        end else if (sub) begin
          mem_read  = 1'b1;
          HREADYOUT = 1'b0;
        end else begin
          mem_write  = 1'b1;
          write_data = HWDATA;
        end
      end
      RMW_WR: begin
        address_ram = word_addr;
        mem_write   = 1'b1;
        write_data  = merge;
      end
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ERR2:    HRESP = 1'b1;
      default: HREADYOUT = 1'b1;
    endcase
  end

  assign mem_sel = mem_read | mem_write;

endmodule
